// File: rtl/uart_rx_serial.sv
// uart_rx_serial: 8N1 (or 8E1) UART receiver with a valid/ready holding register.
// Ports: clk, rst (async, active high), rx_serial (async line, idle high),
//        rx_ready (consumer accept) -> rx_data[7:0], rx_valid,
//        rx_frame_err / rx_overrun / rx_parity_err (one-cycle pulses).
// Build option: define UART_RX_PARITY_EN for an even-parity bit before stop.
`timescale 1ns/1ps
module uart_rx_serial #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_serial,
   input  logic       rx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_frame_err,
   output logic       rx_overrun,
   output logic       rx_parity_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int H  = CLKS_PER_BIT / 2;

   localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] C_HM1  = CW'(H - 1);
   localparam logic [CW-1:0] C_H    = CW'(H);
   localparam logic [CW-1:0] C_HP1  = CW'(H + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
`ifdef UART_RX_PARITY_EN
      , S_PARITY
`endif
   } state_t;

   logic          r_sync1;
   logic          r_sync2;
   logic          w_rxs;
   state_t        r_state;
   state_t        w_next;
   logic [CW-1:0] r_cnt;
   logic          r_s0;
   logic          r_s1;
   logic          w_vote_now;
   logic          w_bit;
   logic [2:0]    r_idx;
   logic [7:0]    r_shift;
   logic          w_shift;
   logic          w_deliver;
   logic          w_ferr;
   logic [7:0]    r_data;
   logic          r_valid;
   logic          r_ferr;
   logic          r_ovr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rx_serial;
         r_sync2 <= r_sync1;
      end
   end

   assign w_rxs = r_sync2;

   // Vote is resolved on the third sample, combining two stored samples
   // with the live synchronized line.
   assign w_vote_now = (r_cnt == C_HP1);
   assign w_bit = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (!w_rxs) w_next = S_START;
         S_START: if (w_vote_now) w_next = w_bit ? S_IDLE : S_DATA;
         S_DATA: begin
            if (w_vote_now && r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
               w_next = S_PARITY;
`else
               w_next = S_STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: if (w_vote_now) w_next = S_STOP;
`endif
         S_STOP:  if (w_vote_now) w_next = w_bit ? S_IDLE : S_BREAK;
         S_BREAK: if (w_rxs) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Output (action) decode
   always_comb begin
      w_shift   = (r_state == S_DATA) && w_vote_now;
      w_deliver = (r_state == S_STOP) && w_vote_now && w_bit;
      w_ferr    = (r_state == S_STOP) && w_vote_now && !w_bit;
   end

   // Counter is held at 0 in IDLE so START begins counting from the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (r_state == S_IDLE || r_cnt == C_LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s0    <= 1'b1;
         r_s1    <= 1'b1;
         r_idx   <= 3'd0;
         r_shift <= 8'h00;
      end else begin
         if (r_cnt == C_HM1) r_s0 <= w_rxs;
         if (r_cnt == C_H)   r_s1 <= w_rxs;
         if (r_state != S_DATA) r_idx <= 3'd0;
         else if (w_shift)      r_idx <= r_idx + 3'd1;
         if (w_shift) r_shift <= {w_bit, r_shift[7:1]};
      end
   end

   // Holding register: a delivery may coincide with a transfer, in which
   // case valid stays high and the data is replaced.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data  <= 8'h00;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_ferr <= w_ferr;
         r_ovr  <= 1'b0;
         if (w_deliver) begin
            if (!r_valid || rx_ready) begin
               r_data  <= r_shift;
               r_valid <= 1'b1;
            end else begin
               r_ovr <= 1'b1;
            end
         end else if (r_valid && rx_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   logic w_par_chk;
   logic r_par_bad;
   logic r_perr;

   assign w_par_chk = (r_state == S_PARITY) && w_vote_now;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_par_bad <= 1'b0;
         r_perr    <= 1'b0;
      end else begin
         if (w_par_chk) r_par_bad <= w_bit ^ (^r_shift);
         r_perr <= w_deliver && (!r_valid || rx_ready) && r_par_bad;
      end
   end

   assign rx_parity_err = r_perr;
`else
   assign rx_parity_err = 1'b0;
`endif

   assign rx_data      = r_data;
   assign rx_valid     = r_valid;
   assign rx_frame_err = r_ferr;
   assign rx_overrun   = r_ovr;

endmodule

// File: tb/tb_uart_rx_serial.sv
// tb_uart_rx_serial: randomized frames against a byte-level reference model.
// Covers reset, glitch, framing error, overrun, mid-frame reset, parity.
`timescale 1ns/1ps
module tb_uart_rx_serial;

   localparam int CPB = 16;
   localparam int H   = CPB / 2;
`ifdef UART_RX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif
   localparam int EXP_LAT = 2 + (FB - 1) * CPB + H + 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_serial = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;
   logic       rx_overrun;
   logic       rx_parity_err;

   uart_rx_serial #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk),
      .rst(rst),
      .rx_serial(rx_serial),
      .rx_ready(rx_ready),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .rx_frame_err(rx_frame_err),
      .rx_overrun(rx_overrun),
      .rx_parity_err(rx_parity_err)
   );

   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;
   int n_vhi, n_ferr, n_ovr, n_perr, n_perr_bad, rise_cyc;
   logic prev_v = 1'b0;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
`ifdef UART_RX_PARITY_EN
   bit par_flip = 1'b0;
`endif

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid && rx_ready) got_q.push_back(rx_data);
         if (rx_valid && !prev_v) rise_cyc = cyc;
         if (rx_valid) n_vhi++;
         if (rx_frame_err) n_ferr++;
         if (rx_overrun) n_ovr++;
         if (rx_parity_err) n_perr++;
         if (rx_parity_err && !rx_valid) n_perr_bad++;
      end
      prev_v = rx_valid;
   end

   task automatic clr();
      n_vhi = 0; n_ferr = 0; n_ovr = 0;
      n_perr = 0; n_perr_bad = 0; rise_cyc = -1;
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_b);
      rx_serial = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_serial = b[i];
         tick(CPB);
      end
`ifdef UART_RX_PARITY_EN
      rx_serial = (^b) ^ par_flip;
      tick(CPB);
`endif
      rx_serial = stop_b;
      tick(CPB);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      int c0;
      clr();
      tick(4);
      chk("rst_data", int'(rx_data), 0);
      chk("rst_valid", int'(rx_valid), 0);
      chk("rst_ferr", int'(rx_frame_err), 0);
      chk("rst_ovr", int'(rx_overrun), 0);
      chk("rst_perr", int'(rx_parity_err), 0);
      rst = 1'b0;
      tick(2 * CPB);

      // single frame, latency, one-cycle valid
      clr();
      rx_ready = 1'b1;
      c0 = cyc;
      send_frame(8'h41, 1'b1);
      tick(CPB);
      chk("f41_n", got_q.size(), 1);
      chk("f41_data", got_q.size() > 0 ? int'(got_q[0]) : -1, 'h41);
      chk("f41_vcyc", n_vhi, 1);
      chk("f41_err", n_ferr + n_ovr + n_perr, 0);
      chk("f41_lat_win",
          int'(rise_cyc - c0 >= EXP_LAT - 1 && rise_cyc - c0 <= EXP_LAT + 1), 1);

      // glitch on idle line
      clr();
      rx_serial = 1'b0;
      tick(6);
      rx_serial = 1'b1;
      tick(3 * CPB);
      chk("glitch_v", n_vhi, 0);
      chk("glitch_ferr", n_ferr, 0);

      // framing error with held break, then a good frame
      clr();
      send_frame(8'hA5, 1'b0);
      rx_serial = 1'b0;
      tick(3 * CPB);
      rx_serial = 1'b1;
      tick(2 * CPB);
      send_frame(8'h3C, 1'b1);
      tick(CPB);
      chk("brk_ferr", n_ferr, 1);
      chk("brk_n", got_q.size(), 1);
      chk("brk_data", got_q.size() > 0 ? int'(got_q[0]) : -1, 'h3C);

      // randomized burst, back-to-back or with random idle gaps
      clr();
      for (int i = 0; i < 24; i++) begin
         b = 8'($urandom);
         exp_q.push_back(b);
         send_frame(b, 1'b1);
         if ($urandom_range(0, 1) == 1) begin
            rx_serial = 1'b1;
            tick($urandom_range(1, 20));
         end
      end
      tick(2 * CPB);
      chk("rnd_n", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         chk($sformatf("rnd_%0d", i),
             i < got_q.size() ? int'(got_q[i]) : -1, int'(exp_q[i]));
      end
      chk("rnd_err", n_ferr + n_ovr + n_perr, 0);

      // overrun with consumer stalled
      clr();
      rx_ready = 1'b0;
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      chk("ovr_valid", int'(rx_valid), 1);
      chk("ovr_data", int'(rx_data), 'h11);
      chk("ovr_n", n_ovr, 1);
      rx_ready = 1'b1;
      chk("ovr_hold", int'(rx_valid), 1);
      tick(1);
      chk("ovr_fall", int'(rx_valid), 0);
      chk("ovr_got", got_q.size() > 0 ? int'(got_q[0]) : -1, 'h11);

      // reset in bit 3 with a byte held
      clr();
      rx_ready = 1'b0;
      tick(CPB);
      send_frame(8'hC3, 1'b1);
      chk("hold_data", int'(rx_data), 'hC3);
      b = 8'h55;
      rx_serial = 1'b0;
      tick(CPB);
      for (int i = 0; i < 3; i++) begin
         rx_serial = b[i];
         tick(CPB);
      end
      rx_serial = b[3];
      tick(H);
      #5 rst = 1'b1;
      #1;
      chk("mrst_valid", int'(rx_valid), 0);
      chk("mrst_data", int'(rx_data), 0);
      chk("mrst_ferr", int'(rx_frame_err), 0);
      rx_serial = 1'b1;
      tick(3);
      rst = 1'b0;
      rx_ready = 1'b1;
      tick(2 * CPB);
      clr();
      send_frame(8'h7E, 1'b1);
      tick(CPB);
      chk("mrst_n", got_q.size(), 1);
      chk("mrst_7e", got_q.size() > 0 ? int'(got_q[0]) : -1, 'h7E);
      chk("mrst_ferr2", n_ferr, 0);

`ifdef UART_RX_PARITY_EN
      clr();
      par_flip = 1'b0;
      send_frame(8'h03, 1'b1);
      tick(CPB);
      chk("par_ok_data", got_q.size() > 0 ? int'(got_q[0]) : -1, 'h03);
      chk("par_ok_perr", n_perr, 0);
      clr();
      par_flip = 1'b1;
      send_frame(8'h03, 1'b1);
      tick(CPB);
      par_flip = 1'b0;
      chk("par_bad_data", got_q.size() > 0 ? int'(got_q[0]) : -1, 'h03);
      chk("par_bad_perr", n_perr, 1);
      chk("par_bad_align", n_perr_bad, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_rx_serial.md
# uart_rx_serial

Standalone UART receiver: recovers 8-bit bytes from an asynchronous serial line (8N1, or 8E1 with parity compiled in) and presents each byte on a valid/ready holding register. It is the receiving end of the team's UART transmitter. It sits between the `rx` pad and any byte consumer (FIFO, command decoder). It also serves as the checker in UART link benches.

## Interface
- `CLKS_PER_BIT`, 5208, `clk` cycles per bit (50 MHz / 9600 baud); legal minimum 8.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_serial`  in  1  asynchronous serial line, idle high.
- `rx_ready`  in  1  consumer accepts `rx_data` this cycle.
- `rx_data`  out  8  received byte; stable while `rx_valid`=1.
- `rx_valid`  out  1  byte held, waiting for `rx_ready`.
- `rx_frame_err`  out  1  one-cycle pulse: stop bit sampled 0.
- `rx_overrun`  out  1  one-cycle pulse: completed byte dropped because holding register full.
- `rx_parity_err`  out  1  one-cycle pulse: parity mismatch (tied 0 without macro).

## Operation
- Input path: 2-flop synchronizer; both flops reset to 1. All logic uses the synchronized line `rxs`.
- Bit counter `cnt` runs 0..CLKS_PER_BIT-1. Bit index runs 0..7.
- Majority vote: samples of `rxs` at `cnt` = H-1, H, H+1, with H = CLKS_PER_BIT/2 (integer). The bit value is the 2-of-3 vote, registered at H+1.
- FSM:
  - IDLE: when `rxs`=0, clear `cnt` and go to START.
  - START: at vote, 1 → false start, return to IDLE, no outputs. 0 → DATA, bit index 0.
  - DATA: at each vote, shift the bit into the shift register, LSB first. After bit 7 → PARITY if the macro is defined, else STOP.
  - PARITY: at vote, compare against even parity of the data.
  - STOP: at vote, 1 → deliver the byte and return to IDLE immediately, at mid-stop, so back-to-back frames are caught. 0 → pulse `rx_frame_err`, discard the byte, go to BREAK.
  - BREAK: wait for `rxs`=1, then IDLE. A held-low line produces exactly one `rx_frame_err`.
- Delivery:
  - Holding register empty, or `rx_ready`=1 in the same cycle → load `rx_data`, `rx_valid`=1.
  - Holding register full and `rx_ready`=0 → pulse `rx_overrun`; the new byte is dropped and the old byte stays.
- Handshake: a transfer happens when `rx_valid`&&`rx_ready`.
  - No delivery that cycle → `rx_valid` falls next cycle.
  - Delivery in the same cycle as a transfer → `rx_valid` stays 1 and `rx_data` updates.
- Parity error (macro on): the byte is still delivered. `rx_parity_err` pulses in the same cycle as the load. This applies only when the stop bit is valid.
- `rx_ready` while `rx_valid`=0 is ignored.

## Timing
- Reset values: `rx_data`=0x00, `rx_valid`=0, all error pulses 0, FSM=IDLE, synchronizer=1.
- Reset mid-frame aborts immediately. After release, the next falling edge on `rxs` is treated as a start bit. The remainder of an aborted frame is therefore re-synchronized (possible frame error) — accepted behaviour.
- Latency, from the falling edge of the start bit at the pin to `rx_valid` rising:
  - 8N1: 2 (sync) + 9·CLKS_PER_BIT + H + 2 cycles, ±1 cycle of input phase.
  - 8E1: add CLKS_PER_BIT.
- Error pulses are exactly 1 `clk` wide and are registered.
- Throughput: continuous frames at nominal baud with zero idle between stop and next start are received. Tolerated baud mismatch is ±2 %.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame is start, 8 data, 1 even-parity bit, stop.
  - PARITY state present; `rx_parity_err` is driven.
- `UART_RX_PARITY_EN` undefined:
  - Frame is 8N1; PARITY state absent.
  - `rx_parity_err` is constant 0. The port list is unchanged.

## Test plan
All scenarios use `CLKS_PER_BIT`=16, `clk` at 50 MHz.
- Frame 0x41, 8N1, `rx_ready`=1 → `rx_valid` high for 1 cycle with `rx_data`=0x41; no error pulses.
- Low glitch of 6 clocks on idle line → FSM returns to IDLE; `rx_valid`, `rx_frame_err` stay 0.
- Frame 0xA5 with stop bit 0, line held low 3 bit times, then high, then frame 0x3C → exactly one `rx_frame_err`; 0xA5 never appears; 0x3C delivered.
- Frames 0x11, 0x22 back-to-back, `rx_ready`=0 → `rx_data`=0x11 held and `rx_overrun` pulses once. Then `rx_ready`=1 → `rx_valid` falls next cycle.
- `rst` asserted during bit 3 of 0x55 → outputs at reset values within the same cycle; after release, frame 0x7E delivered correctly.
- Macro on: 0x03 with parity 0 → clean delivery. 0x03 with parity 1 → delivered with one `rx_parity_err` pulse in the same cycle.
